alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Command front-end that sits directly upstream of the ALU and also collects what the ALU produces.
- Buffers operation commands (a, b, select, tag) arriving over a valid/ready interface in a command FIFO.
- Issues one command per cycle to the ALU, tracks the ALU's registered one-cycle latency, and captures each result together with its comparator flags and tag.
- Returns results, in issue order, through a result FIFO with its own valid/ready handshake.

Parameters:
- WIDTH, 4, operand width; ALU result width is 2*WIDTH.
- TAG_W, 4, width of the user tag carried from command to result.
- CMD_DEPTH, 4, command FIFO entries; power of two, at least 2.
- RES_DEPTH, 4, result FIFO entries; power of two, at least 3.

Ports:
- clk  in  1  single clock, rising edge.
- arst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_a  in  WIDTH  operand a.
- cmd_b  in  WIDTH  operand b.
- cmd_sel  in  3  ALU operation select.
- cmd_tag  in  TAG_W  user tag.
- alu_a  out  WIDTH  registered operand a to the ALU.
- alu_b  out  WIDTH  registered operand b to the ALU.
- alu_select  out  3  registered select to the ALU.
- alu_enable  out  1  registered; high only in issue cycles.
- alu_out  in  2*WIDTH  ALU registered result.
- alu_carry  in  1  ALU registered carry.
- alu_greater  in  1  ALU combinational comparator flag.
- alu_equal  in  1  ALU combinational comparator flag.
- alu_less  in  1  ALU combinational comparator flag.
- res_valid  out  1  result FIFO not empty.
- res_ready  in  1  consumer accepts the result.
- res_data  out  2*WIDTH  result value.
- res_carry  out  1  captured carry.
- res_flags  out  3  captured comparator flags as {greater, equal, less}.
- res_div0  out  1  result came from select 111 with b == 0.
- res_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (arst low, asynchronous):
  - Both FIFOs are emptied and all pipeline valid bits are cleared.
  - alu_a, alu_b, alu_select, alu_enable, res_data, res_carry, res_flags, res_div0 and res_tag are all 0.
  - cmd_ready = 1 and res_valid = 0.
  - Release is synchronous to clk.
  - Reset during an operation discards every command in flight; nothing partial is ever emitted.
- Command push: occurs when cmd_valid && cmd_ready. cmd_ready = (cmd_count < CMD_DEPTH) and is a registered count compare, not a function of the pop in the same cycle.
- Issue condition: command FIFO not empty AND (res_count + inflight - res_pop) < RES_DEPTH.
  - inflight = number of valid stage-1 and stage-2 slots (0..2).
  - res_pop = res_valid && res_ready.
- Issue actions, at edge N:
  - Pop the command FIFO head.
  - Register it onto alu_a, alu_b and alu_select, and set alu_enable = 1.
  - Load stage-1 with valid = 1, tag, sel and div0 = (sel == 3'b111 && b == 0).
- Idle cycle: alu_enable = 0 and alu_a, alu_b, alu_select hold their previous values.
- Edge N+1:
  - The ALU registers its result.
  - This block samples alu_greater/equal/less into stage-2 along with stage-1 contents. The flags are valid only in cycle N..N+1 because they are combinational.
- Edge N+2: stage-2 is written into the result FIFO together with alu_out and alu_carry.
- Total latency from accepted cmd to res_valid is 3 cycles minimum when the FIFO was empty: cmd accepted at edge 0, issued at edge 1, written at edge 3, res_valid visible after edge 3.
- Throughput is 1 result per cycle when res_ready is held high.
- Ordering: results are strictly in command order; tags are not reordered.
- Credit rule: the issue condition guarantees the result FIFO never overflows. A stage-2 write is never dropped.
- Result FIFO output fields are registered at the head entry and are stable while res_valid && !res_ready.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle leave the count unchanged.
  - Push into an empty command FIFO is not issued in the same cycle (one-cycle bubble).
- Wrap-around: read and write pointers are log2(depth) bits and wrap modulo depth; counts are separate registers of log2(depth)+1 bits.
- div0: division by zero is flagged only. res_data passes through whatever the ALU produced.

Test Plan:
- Reset then single cmd (a=3, b=5, sel=000, tag=1), res_ready=1 -> res_valid after 3 edges; res_data=8, res_carry=0, res_flags=3'b001, res_tag=1.
- Back-to-back cmds with sel 110 (a=15, b=15), 001 (a=9, b=4), 011 (a=10, b=5), tags 2,3,4 -> results 225, 5, 15 on consecutive cycles in tag order 2,3,4.
- res_ready=0, push 8 cmds (WIDTH=4, depths=4) -> alu_enable pulses exactly 4 times and cmd_ready drops after the FIFO fills. Release res_ready -> all 8 results arrive in order with none lost or duplicated.
- cmd a=7, b=0, sel=111 -> res_div0=1, res_flags=3'b100. Then a=8, b=2, sel=111 -> res_div0=0, res_data=4.
- a=15, b=1, sel=000 -> res_data=0 in the low WIDTH bits, res_carry=1. Then sel=001 with same operands -> res_carry=0.
- Assert arst while 2 ops are in flight and 2 are queued -> res_valid=0 and cmd_ready=1 immediately. After release, a new cmd returns a correct result with no stale results emitted.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands, issues one per cycle, tracks latency and returns results in order
module alu_op_sequencer #(
  parameter int WIDTH     = 4,
  parameter int TAG_W     = 4,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [2:0]         cmd_sel,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_select,
  output logic               alu_enable,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_carry,
  input  logic               alu_greater,
  input  logic               alu_equal,
  input  logic               alu_less,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_carry,
  output logic [2:0]         res_flags,
  output logic               res_div0,
  output logic [TAG_W-1:0]   res_tag
);
  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int RPW = $clog2(RES_DEPTH);
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic [TAG_W-1:0] tag;
  } cmd_t;
  typedef struct packed {
    logic [2*WIDTH-1:0] data;
    logic               carry;
    logic [2:0]         flags;
    logic               div0;
    logic [TAG_W-1:0]   tag;
  } res_t;
  cmd_t             cmd_mem_q [CMD_DEPTH];
  logic [CPW-1:0]   cmd_wp_q, cmd_rp_q;
  logic [CPW:0]     cmd_cnt_q, cmd_cnt_d;
  res_t             res_mem_q [RES_DEPTH];
  logic [RPW-1:0]   res_wp_q, res_rp_q;
  logic [RPW:0]     res_cnt_q, res_cnt_d;
  logic             s1_v_q, s1_div0_q, s2_v_q, s2_div0_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  logic [2:0]       s2_flags_q;
  logic [RPW+1:0]   occ;
  logic             push, issue, res_pop;
  cmd_t             head;
  assign cmd_ready = cmd_cnt_q < (CPW+1)'(CMD_DEPTH);
  assign res_valid = res_cnt_q != '0;
  assign push      = cmd_valid && cmd_ready;
  assign res_pop   = res_valid && res_ready;
  assign head      = cmd_mem_q[cmd_rp_q];
  // Credit check: queued results plus everything in the ALU pipe must fit once this cycle's pop is taken.
  assign occ       = (RPW+2)'(res_cnt_q) + (RPW+2)'(s1_v_q) + (RPW+2)'(s2_v_q);
  assign issue     = cmd_cnt_q != '0 && occ < (RPW+2)'(RES_DEPTH) + (RPW+2)'(res_pop);
  assign cmd_cnt_d = cmd_cnt_q + (CPW+1)'(push) - (CPW+1)'(issue);
  assign res_cnt_d = res_cnt_q + (RPW+1)'(s2_v_q) - (RPW+1)'(res_pop);
  assign {res_data, res_carry, res_flags, res_div0, res_tag} = res_mem_q[res_rp_q];
  always_ff @(posedge clk) begin
    if (push) cmd_mem_q[cmd_wp_q] <= {cmd_a, cmd_b, cmd_sel, cmd_tag};
  end
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cmd_wp_q   <= '0;
      cmd_rp_q   <= '0;
      cmd_cnt_q  <= '0;
      res_wp_q   <= '0;
      res_rp_q   <= '0;
      res_cnt_q  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
      alu_enable <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_div0_q  <= 1'b0;
      s1_tag_q   <= '0;
      s2_v_q     <= 1'b0;
      s2_div0_q  <= 1'b0;
      s2_tag_q   <= '0;
      s2_flags_q <= '0;
      for (int i = 0; i < RES_DEPTH; i++) res_mem_q[i] <= '0;
    end else begin
      cmd_wp_q   <= cmd_wp_q + CPW'(push);
      cmd_rp_q   <= cmd_rp_q + CPW'(issue);
      cmd_cnt_q  <= cmd_cnt_d;
      alu_enable <= issue;
      s1_v_q     <= issue;
      if (issue) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_select <= head.sel;
        s1_tag_q   <= head.tag;
        s1_div0_q  <= head.sel == 3'b111 && head.b == '0;
      end
      // Comparator flags are combinational on the issued operands, so they are caught one edge after issue.
      s2_v_q     <= s1_v_q;
      s2_tag_q   <= s1_tag_q;
      s2_div0_q  <= s1_div0_q;
      s2_flags_q <= {alu_greater, alu_equal, alu_less};
      if (s2_v_q) res_mem_q[res_wp_q] <= {alu_out, alu_carry, s2_flags_q, s2_div0_q, s2_tag_q};
      res_wp_q   <= res_wp_q + RPW'(s2_v_q);
      res_rp_q   <= res_rp_q + RPW'(res_pop);
      res_cnt_q  <= res_cnt_d;
    end
  end
endmodule
